// File: rtl/gyro_integ_pkg.sv
// Shared types and constants for the gyro angle integrator: FSM states,
// rate/angle widths and signed saturation limits.
package gyro_integ_pkg;

  localparam int unsigned RATE_W = 16;
  localparam int unsigned OUT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACC_X,
    ACC_Y,
    ACC_Z,
    PUBLISH
  } state_e;

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/gyro_integrator_sat_add.sv
// Signed W-bit adder that clamps to the representable range instead of wrapping.
module sat_add
  import gyro_integ_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

  logic [W:0] full;

  assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  // Top two bits disagree exactly when the W+1-bit sum left the W-bit range.
  always_comb begin
    if (full[W] != full[W-1]) begin
      sum_o = full[W] ? MIN_V : MAX_V;
    end else begin
      sum_o = full[W-1:0];
    end
  end

endmodule

// File: rtl/gyro_integrator.sv
// Integrates gyro rates into three saturating angle accumulators on one shared adder.
// Optional build macro GYRO_DEADBAND_EN zeroes small rates when they are latched.
module gyro_integrator
  import gyro_integ_pkg::*;
#(
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_SHIFT = 8,
  parameter int          DEADBAND  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic signed [RATE_W-1:0] rate_x,
  input  logic signed [RATE_W-1:0] rate_y,
  input  logic signed [RATE_W-1:0] rate_z,
  input  logic                     done_read,
  output logic signed [OUT_W-1:0]  angle_x,
  output logic signed [OUT_W-1:0]  angle_y,
  output logic signed [OUT_W-1:0]  angle_z,
  output logic                     angle_valid,
  output logic                     busy,
  output logic                     overrun
);

  if (ACC_W < RATE_W + 1 || DEADBAND < 0) begin : g_param_check
    $error("gyro_integrator: ACC_W must be >= 17 and DEADBAND >= 0");
  end

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(sat_min(OUT_W));

`ifdef GYRO_DEADBAND_EN
  localparam logic signed [RATE_W-1:0] DB = RATE_W'(DEADBAND);
  function automatic logic signed [RATE_W-1:0] shape(input logic signed [RATE_W-1:0] r);
    return (r >= -DB && r <= DB) ? '0 : r;
  endfunction
`else
  function automatic logic signed [RATE_W-1:0] shape(input logic signed [RATE_W-1:0] r);
    return r;
  endfunction
`endif

  function automatic logic signed [OUT_W-1:0] to_angle(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> OUT_SHIFT;
    if (s > OUT_MAX) return OUT_W'(OUT_MAX);
    if (s < OUT_MIN) return OUT_W'(OUT_MIN);
    return OUT_W'(s);
  endfunction

  state_e                    state_q, state_d;
  logic                      done_q;
  logic signed [RATE_W-1:0]  rx_q, ry_q, rz_q, rx_d, ry_d, rz_d;
  logic signed [ACC_W-1:0]   ax_q, ay_q, az_q, ax_d, ay_d, az_d;
  logic signed [OUT_W-1:0]   angx_q, angy_q, angz_q, angx_d, angy_d, angz_d;
  logic                      ovr_q, ovr_d;
  logic                      start;
  logic signed [ACC_W-1:0]   add_a, add_b, add_sum;

  assign start = done_read & ~done_q;

  always_comb begin
    add_a = ax_q;
    add_b = ACC_W'(rx_q);
    case (state_q)
      ACC_Y: begin
        add_a = ay_q;
        add_b = ACC_W'(ry_q);
      end
      ACC_Z: begin
        add_a = az_q;
        add_b = ACC_W'(rz_q);
      end
      default: ;
    endcase
  end

  sat_add #(.W(ACC_W)) u_sat_add (
    .a_i  (add_a),
    .b_i  (add_b),
    .sum_o(add_sum)
  );

  // Angles load on the ACC_Z->PUBLISH edge (z taken straight from the adder)
  // so they change in the same cycle the valid strobe is high.
  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rz_d    = rz_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    az_d    = az_q;
    angx_d  = angx_q;
    angy_d  = angy_q;
    angz_d  = angz_q;
    ovr_d   = ovr_q;
    if (clear) begin
      state_d = IDLE;
      ax_d    = '0;
      ay_d    = '0;
      az_d    = '0;
      angx_d  = '0;
      angy_d  = '0;
      angz_d  = '0;
      ovr_d   = 1'b0;
    end else begin
      if (start && state_q != IDLE) ovr_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            rx_d    = shape(rate_x);
            ry_d    = shape(rate_y);
            rz_d    = shape(rate_z);
            state_d = ACC_X;
          end
        end
        ACC_X: begin
          ax_d    = add_sum;
          state_d = ACC_Y;
        end
        ACC_Y: begin
          ay_d    = add_sum;
          state_d = ACC_Z;
        end
        ACC_Z: begin
          az_d    = add_sum;
          angx_d  = to_angle(ax_q);
          angy_d  = to_angle(ay_q);
          angz_d  = to_angle(add_sum);
          state_d = PUBLISH;
        end
        PUBLISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rz_q    <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      az_q    <= '0;
      angx_q  <= '0;
      angy_q  <= '0;
      angz_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_read;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rz_q    <= rz_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      az_q    <= az_d;
      angx_q  <= angx_d;
      angy_q  <= angy_d;
      angz_q  <= angz_d;
      ovr_q   <= ovr_d;
    end
  end

  assign angle_x     = angx_q;
  assign angle_y     = angy_q;
  assign angle_z     = angz_q;
  assign angle_valid = (state_q == PUBLISH);
  assign busy        = (state_q != IDLE);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_gyro_integrator.sv
// Scoreboard bench for gyro_integrator: a cycle-stamped reference model queues
// expected angle updates, a negedge monitor checks every strobe plus busy/overrun.
module tb_gyro_integrator;

  localparam int ACC_W = 17;
  localparam longint ACC_HI = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint ACC_LO = -(64'sd1 <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic done_read = 1'b0;
  logic signed [15:0] rate_x = '0, rate_y = '0, rate_z = '0;
  logic signed [15:0] angle_x, angle_y, angle_z;
  logic angle_valid, busy, overrun;

  gyro_integrator #(.ACC_W(ACC_W), .OUT_SHIFT(8), .DEADBAND(4)) dut (
    .clk(clk), .rst(rst_n), .clear(clear),
    .rate_x(rate_x), .rate_y(rate_y), .rate_z(rate_z), .done_read(done_read),
    .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z),
    .angle_valid(angle_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    longint per;
    longint ax, ay, az;
  } exp_t;

  exp_t   exp_q[$];
  longint cyc = 0;
  longint m_free = 0;
  longint m_acc[3];
  bit     m_prev = 1'b0;
  bit     m_ovr = 1'b0;

  function automatic longint m_shape(input longint r);
`ifdef GYRO_DEADBAND_EN
    if (r >= -4 && r <= 4) return 0;
`endif
    return r;
  endfunction

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint m_angle(input longint a);
    return clampl(a >>> 8, -32768, 32767);
  endfunction

  // Reference model: a sample accepted in period p occupies the block for
  // periods p+1..p+4 and its angles are visible in period p+4.
  always @(posedge clk) begin
    exp_t e;
    bit st;
    cyc++;
    if (!rst_n) begin
      m_acc = '{0, 0, 0};
      m_prev = 1'b0;
      m_ovr = 1'b0;
      m_free = 0;
      exp_q.delete();
    end else begin
      st = done_read && !m_prev;
      m_prev = done_read;
      if (clear) begin
        m_acc = '{0, 0, 0};
        m_ovr = 1'b0;
        m_free = 0;
        exp_q.delete();
      end else if (st) begin
        if (cyc < m_free) begin
          m_ovr = 1'b1;
        end else begin
          m_acc[0] = clampl(m_acc[0] + m_shape(rate_x), ACC_LO, ACC_HI);
          m_acc[1] = clampl(m_acc[1] + m_shape(rate_y), ACC_LO, ACC_HI);
          m_acc[2] = clampl(m_acc[2] + m_shape(rate_z), ACC_LO, ACC_HI);
          e.per = cyc + 4;
          e.ax = m_angle(m_acc[0]);
          e.ay = m_angle(m_acc[1]);
          e.az = m_angle(m_acc[2]);
          exp_q.push_back(e);
          m_free = cyc + 5;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (angle_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_cycle", cyc + 1, e.per);
          chk("angle_x", angle_x, e.ax);
          chk("angle_y", angle_y, e.ay);
          chk("angle_z", angle_z, e.az);
        end
      end
      if (busy != (cyc + 1 < m_free)) chk("busy", busy, longint'(cyc + 1 < m_free));
      if (overrun != m_ovr) chk("overrun", overrun, m_ovr);
    end
  end

  task automatic pulse(input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic signed [15:0] z, input int gap);
    @(negedge clk);
    rate_x = x; rate_y = y; rate_z = z;
    done_read = 1'b1;
    @(negedge clk);
    done_read = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ax"}, angle_x, 0);
    chk({tag, "_ay"}, angle_y, 0);
    chk({tag, "_az"}, angle_z, 0);
    chk({tag, "_valid"}, angle_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all_zero("idle");

    pulse(16'sd256, -16'sd512, 16'sd0, 6);
    chk("t2_ax", angle_x, 1);
    chk("t2_ay", angle_y, -2);
    chk("t2_az", angle_z, 0);

    @(negedge clk);
    rate_x = 16'sd512; rate_y = 16'sd0; rate_z = 16'sd0;
    done_read = 1'b1;
    repeat (20) @(negedge clk);
    done_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_held_ax", angle_x, 3);
    pulse(16'sd256, 16'sd0, 16'sd0, 0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = angle_valid;
    end
    chk("t3_valid_seen", seen, 1);
    pulse(16'sd256, 16'sd0, 16'sd0, 6);
    chk("t3_b2b_ax", angle_x, 5);
    chk("t3_b2b_ovr", overrun, 0);

    for (int i = 0; i < 300; i++) pulse(16'sd32767, -16'sd32768, 16'sd100, 4);
    repeat (2) @(negedge clk);
    chk("t4_sat_ax", angle_x, 255);
    chk("t4_sat_ay", angle_y, -256);

    do_clear();
    pulse(16'sd1000, 16'sd0, 16'sd0, 0);
    pulse(16'sd2000, 16'sd0, 16'sd0, 8);
    chk("t5_ax", angle_x, 3);
    chk("t5_ovr", overrun, 1);
    do_clear();
    chk("t5_clr_ovr", overrun, 0);
    chk("t5_clr_ax", angle_x, 0);

    for (int i = 0; i < 100; i++) pulse(16'sd3, 16'sd0, 16'sd0, 4);
    repeat (2) @(negedge clk);
`ifdef GYRO_DEADBAND_EN
    chk("t6_db3_ax", angle_x, 0);
`else
    chk("t6_db3_ax", angle_x, 1);
`endif
    for (int i = 0; i < 100; i++) pulse(16'sd5, 16'sd0, 16'sd0, 4);
    repeat (2) @(negedge clk);
`ifdef GYRO_DEADBAND_EN
    chk("t6_db5_ax", angle_x, 1);
`else
    chk("t6_db5_ax", angle_x, 3);
`endif

    @(negedge clk);
    rate_x = 16'sd7000; rate_y = 16'sd7000; rate_z = 16'sd7000;
    done_read = 1'b1;
    @(negedge clk);
    done_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_all_zero("t6_after_rst");

    for (int i = 0; i < 60; i++) begin
      logic signed [15:0] x, y, z;
      x = 16'($urandom_range(0, 65535));
      y = 16'($signed($urandom_range(0, 4000)) - 2000);
      z = 16'($signed($urandom_range(0, 20)) - 10);
      if ($urandom_range(0, 9) == 0) do_clear();
      pulse(x, y, z, $urandom_range(0, 6));
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
